reg_alu_sequencer: RTL

//  Execute stage directly upstream of reg_file_4x8: accepts one register-register/immediate

---
 rtl/reg_alu_pkg.sv | 23 ++
 rtl/reg_alu_core.sv | 38 +++
 rtl/reg_file_4x8.sv | 27 ++
 rtl/reg_alu_sequencer.sv | 125 ++++++++++++
 4 files changed

// File: rtl/reg_alu_pkg.sv
// Shared widths, opcodes and FSM state encoding for the register-file ALU sequencer.
package reg_alu_pkg;

   localparam int DEFAULT_DATA_W = 8;
   localparam int DEFAULT_ADDR_W = 2;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_MOV = 3'd5;
   localparam logic [2:0] OP_LDI = 3'd6;
   localparam logic [2:0] OP_NOP = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } seq_state_t;

endpackage

// File: rtl/reg_alu_core.sv
// Combinational ALU: result plus carry/borrow and zero flags for one opcode.
module reg_alu_core
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              c,
   output logic              z
);

   logic [DATA_W:0] sum;
   logic [DATA_W:0] diff;

   // The extra top bit of the widened difference is the unsigned borrow (a < b).
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = '0;
      c      = 1'b0;
      case (op)
         OP_ADD:  {c, result} = sum;
         OP_SUB:  {c, result} = diff;
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_MOV:  result = a;
         OP_LDI:  result = imm;
         default: result = '0;
      endcase
      z = (result == '0);
   end

endmodule

// File: rtl/reg_file_4x8.sv
// Four-entry register file: two combinational read ports, one synchronous write port.
module reg_file_4x8
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] read_addr1,
   output logic [DATA_W-1:0] read_data1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data2,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data
);

   logic [DATA_W-1:0] regs [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (write_en) regs[write_addr] <= write_data;
   end

   assign read_data1 = regs[read_addr1];
   assign read_data2 = regs[read_addr2];

endmodule

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle execute stage: accept, read operands, execute, write back, one instruction at a time.
module reg_alu_sequencer
   import reg_alu_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [DATA_W-1:0] in_imm,
   output logic [ADDR_W-1:0] read_addr1,
   output logic [ADDR_W-1:0] read_addr2,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              done,
   output logic              flag_c,
   output logic              flag_z
);

   seq_state_t        state;
   seq_state_t        next_state;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [ADDR_W-1:0] rs1_q;
   logic [ADDR_W-1:0] rs2_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] opa;
   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] result;
   logic [DATA_W-1:0] alu_result;
   logic              alu_c;
   logic              alu_z;

   reg_alu_core #(.DATA_W(DATA_W)) u_core (
      .op     (op_q),
      .a      (opa),
      .b      (opb),
      .imm    (imm_q),
      .result (alu_result),
      .c      (alu_c),
      .z      (alu_z)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // write_en/done come straight from the state so a reset drops them immediately.
   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      write_en   = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) next_state = READ;
         end
         READ: next_state = EXEC;
         EXEC: next_state = WB;
         WB: begin
            write_en   = (op_q != OP_NOP);
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A NOP leaves both the result register and the flags untouched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q   <= '0;
         rd_q   <= '0;
         rs1_q  <= '0;
         rs2_q  <= '0;
         imm_q  <= '0;
         opa    <= '0;
         opb    <= '0;
         result <= '0;
         flag_c <= 1'b0;
         flag_z <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_q  <= in_op;
                  rd_q  <= in_rd;
                  rs1_q <= in_rs1;
                  rs2_q <= in_rs2;
                  imm_q <= in_imm;
               end
            end
            READ: begin
               opa <= read_data1;
               opb <= read_data2;
            end
            EXEC: begin
               if (op_q != OP_NOP) begin
                  result <= alu_result;
                  flag_c <= alu_c;
                  flag_z <= alu_z;
               end
            end
            default: ;
         endcase
      end
   end

   assign read_addr1 = rs1_q;
   assign read_addr2 = rs2_q;
   assign write_addr = rd_q;
   assign write_data = result;

endmodule
